// File: rtl/bitwrite_pkg.sv
// Shared types for the bit-RAM write queue: FSM states, queue entry layout
// and the saturation point of the request age counter.
package bitwrite_pkg;

  localparam int ADDR_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } bw_state_e;

  typedef struct packed {
    logic [ADDR_W_DEFAULT-1:0] addr;
    logic                      data;
  } bw_entry_t;

  // The first genuine ACK arrives two cycles after WE rises.
  localparam logic [1:0] AGE_SAT = 2'd2;

endpackage

// File: rtl/bitwrite_fifo.sv
// Register-based ring buffer holding pending bit writes; head is read
// straight from the storage registers so it stays stable until popped.
module bitwrite_fifo
  import bitwrite_pkg::*;
#(
  parameter int  DEPTH   = 8,
  parameter type entry_t = bw_entry_t,
  localparam int PTR_W   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           srst,
  input  logic           push,
  input  entry_t         push_entry,
  input  logic           pop,
  output entry_t         head,
  output logic [PTR_W:0] count,
  output logic           full
);

  entry_t           mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == (PTR_W+1)'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && (count_reg != '0);
  assign head    = mem_reg[rd_ptr_reg];
  assign count   = count_reg;

  // Storage carries no reset; the head is only observed while entries exist.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (push_ok && (wr_ptr_reg == PTR_W'(gi))) begin
        mem_reg[gi] <= push_entry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/bitwrite_queue.sv
// Per-core buffered bit-write front-end: queues core writes and hands the
// head entry to the arbiter, holding it until an ACK that can be genuine.
module bitwrite_queue
  import bitwrite_pkg::*;
#(
  parameter int  DEPTH  = 8,
  parameter int  ADDR_W = ADDR_W_DEFAULT,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              BITWRITEQUEUE_PUSH,
  input  logic              BITWRITEQUEUE_PUSH_DATA,
  input  logic [ADDR_W-1:0] BITWRITEQUEUE_PUSH_ADDR,
  output logic              BITWRITEQUEUE_READY,
  output logic              BITWRITEQUEUE_WE,
  output logic              BITWRITEQUEUE_WriteDATA,
  output logic [ADDR_W-1:0] BITWRITEQUEUE_WriteADDR,
  input  logic              BITWRITEQUEUE_ACK,
  output logic [CNT_W-1:0]  BITWRITEQUEUE_COUNT,
  output logic              BITWRITEQUEUE_IDLE
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              data;
  } entry_t;

  bw_state_e        state_reg;
  bw_state_e        state_next;
  logic [1:0]       age_reg;
  logic [1:0]       age_next;
  logic             we_reg;
  logic             srst;
  logic             push_ok;
  logic             ack_ok;
  logic             pop;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;
  entry_t           push_entry;
  entry_t           head;

  assign srst       = !RESET_N;
  assign push_ok    = BITWRITEQUEUE_PUSH && !fifo_full;
  assign push_entry = '{addr: BITWRITEQUEUE_PUSH_ADDR, data: BITWRITEQUEUE_PUSH_DATA};
  // Early ACKs belong to an earlier request's duplicate grant, so ignore them.
  assign ack_ok     = (state_reg == REQ) && (age_reg >= AGE_SAT) && BITWRITEQUEUE_ACK;
  assign pop        = (state_reg == HOLD);

  bitwrite_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk        (CLK),
    .srst       (srst),
    .push       (BITWRITEQUEUE_PUSH),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (fifo_count),
    .full       (fifo_full)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_reg <= IDLE;
      age_reg   <= '0;
      we_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      age_reg   <= age_next;
      we_reg    <= (state_next == REQ);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (fifo_count != '0) state_next = REQ;
      REQ:  if (ack_ok) state_next = HOLD;
      // The head pops this edge; a same-cycle push also counts as remaining work.
      HOLD: state_next = ((fifo_count > CNT_W'(1)) || push_ok) ? REQ : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    age_next = 2'd0;
    if ((state_reg == REQ) && (state_next == REQ)) begin
      age_next = (age_reg >= AGE_SAT) ? age_reg : age_reg + 2'd1;
    end
  end

  assign BITWRITEQUEUE_WE        = we_reg;
  assign BITWRITEQUEUE_WriteADDR = (state_reg != IDLE) ? head.addr : '0;
  assign BITWRITEQUEUE_WriteDATA = (state_reg != IDLE) ? head.data : 1'b0;
  assign BITWRITEQUEUE_READY     = !fifo_full;
  assign BITWRITEQUEUE_COUNT     = fifo_count;
  assign BITWRITEQUEUE_IDLE      = (fifo_count == '0) && (state_reg == IDLE);

endmodule
